// File: rtl/edge_det_pkg.sv
// Shared types and combine functions for the all-directions edge detector.
// Optional feature macro: EDGE_THRESHOLD_EN (selects thresholded binary edge map).
package edge_det_pkg;

  localparam int unsigned DataWDefault = 8;

  // {buffLRMode, buffUDMode}; the two mixed encodings both mean hold
  typedef enum logic [1:0] {
    ModeLoad   = 2'b00,
    ModeHoldUd = 2'b01,
    ModeHoldLr = 2'b10,
    ModeRead   = 2'b11
  } mode_e;

  // Saturating add of two w-bit gradients
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] maxv;
    sum  = {1'b0, a} + {1'b0, b};
    maxv = (33'd1 << w) - 33'd1;
    if (sum > maxv) return 32'(maxv);
    return 32'(sum);
  endfunction

  // Binary edge map: all-ones when the gradient sum reaches thresh
  function automatic logic [31:0] thresh_map(input logic [31:0] a, input logic [31:0] b,
                                             input int unsigned w, input int unsigned thresh);
    logic [32:0] sum;
    logic [32:0] maxv;
    sum  = {1'b0, a} + {1'b0, b};
    maxv = (33'd1 << w) - 33'd1;
    if (sum >= 33'(thresh)) return 32'(maxv);
    return 32'd0;
  endfunction

endpackage

// File: rtl/edge_detection_all_directions_grad.sv
// Gradient stream unit: holds the previous pixel and the stream pointer, produces the
// absolute difference against the previous pixel of the same line and the buffer address.
// ColMajor selects column-major (up-down) address mapping; otherwise row-major.
module grad_stream_unit
  import edge_det_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned HEIGHT   = 16,
  parameter int unsigned DATA_W   = DataWDefault,
  parameter bit          ColMajor = 1'b0,
  localparam int unsigned N       = WIDTH * HEIGHT,
  localparam int unsigned PtrW    = $clog2(N + 1),
  localparam int unsigned AddrW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] pix_i,
  output logic              we_o,
  output logic [AddrW-1:0]  waddr_o,
  output logic [DATA_W-1:0] wdata_o
);

  logic [PtrW-1:0]   ptr_q;
  logic [DATA_W-1:0] prev_q;
  logic              accept;
  logic              first;
  logic [DATA_W-1:0] diff;
  int unsigned       idx;
  int unsigned       addr;

  // Pointer saturates at N; pixels beyond the image are dropped
  assign accept = step_i && (ptr_q != PtrW'(N));

  // Address mapping and first-of-line detection
  always_comb begin
    idx   = 32'(ptr_q);
    first = 1'b0;
    addr  = 0;
    if (ColMajor) begin
      first = (idx % HEIGHT) == 0;
      addr  = (idx % HEIGHT) * WIDTH + idx / HEIGHT;
    end else begin
      first = (idx % WIDTH) == 0;
      addr  = idx;
    end
  end

  // Unsigned absolute difference, forced to zero at the start of each line
  always_comb begin
    diff = (pix_i >= prev_q) ? (pix_i - prev_q) : (prev_q - pix_i);
    wdata_o = first ? '0 : diff;
    waddr_o = AddrW'(addr);
    we_o    = accept;
  end

  // Pointer and previous-pixel state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      prev_q <= '0;
    end else if (clr_i) begin
      ptr_q  <= '0;
      prev_q <= '0;
    end else if (accept) begin
      ptr_q  <= ptr_q + PtrW'(1);
      prev_q <= pix_i;
    end
  end

endmodule

// File: rtl/edge_detection_all_directions.sv
// Streaming edge detector: loads horizontal/vertical gradients of one image from a
// row-major and a column-major stream, then streams out the combined edge values.
// Optional feature macro: EDGE_THRESHOLD_EN (binary edge map against THRESH).
module edge_detection_all_directions
  import edge_det_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned HEIGHT = 16,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned THRESH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              resetBuff,
  input  logic              enb,
  input  logic              buffLRMode,
  input  logic              buffUDMode,
  input  logic [DATA_W-1:0] leftRightArray,
  input  logic [DATA_W-1:0] upDownArray,
  output logic [DATA_W-1:0] OutArray,
  output logic              complete
);

  localparam int unsigned N     = WIDTH * HEIGHT;
  localparam int unsigned PtrW  = $clog2(N + 1);
  localparam int unsigned AddrW = (N > 1) ? $clog2(N) : 1;

  mode_e             mode;
  logic              load_step;
  logic              read_step;
  logic              lr_we, ud_we;
  logic [AddrW-1:0]  lr_addr, ud_addr;
  logic [DATA_W-1:0] lr_data, ud_data;
  logic [DATA_W-1:0] gx_mem [N];
  logic [DATA_W-1:0] gy_mem [N];
  logic [PtrW-1:0]   rd_ptr_q;
  logic [AddrW-1:0]  rd_addr;
  logic [DATA_W-1:0] out_next;

  assign mode      = mode_e'({buffLRMode, buffUDMode});
  // Buffer writes are suppressed while either reset is active
  assign load_step = enb && reset && !resetBuff && (mode == ModeLoad);
  assign read_step = enb && (mode == ModeRead) && !complete;
  assign rd_addr   = rd_ptr_q[AddrW-1:0];

  grad_stream_unit #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .DATA_W  (DATA_W),
    .ColMajor(1'b0)
  ) u_lr (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (resetBuff),
    .step_i (load_step),
    .pix_i  (leftRightArray),
    .we_o   (lr_we),
    .waddr_o(lr_addr),
    .wdata_o(lr_data)
  );

  grad_stream_unit #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .DATA_W  (DATA_W),
    .ColMajor(1'b1)
  ) u_ud (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (resetBuff),
    .step_i (load_step),
    .pix_i  (upDownArray),
    .we_o   (ud_we),
    .waddr_o(ud_addr),
    .wdata_o(ud_data)
  );

  // Gradient buffers; contents survive both resets
  always_ff @(posedge clk) begin
    if (lr_we) gx_mem[lr_addr] <= lr_data;
    if (ud_we) gy_mem[ud_addr] <= ud_data;
  end

  // Combine the two gradients of the pixel being read
`ifdef EDGE_THRESHOLD_EN
  always_comb begin
    out_next = DATA_W'(thresh_map(32'(gx_mem[rd_addr]), 32'(gy_mem[rd_addr]), DATA_W, THRESH));
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;

  always_comb begin
    out_next = DATA_W'(sat_add(32'(gx_mem[rd_addr]), 32'(gy_mem[rd_addr]), DATA_W));
  end
`endif

  // Readout pointer, registered output and sticky completion flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      OutArray <= '0;
      complete <= 1'b0;
    end else if (resetBuff) begin
      rd_ptr_q <= '0;
      complete <= 1'b0;
    end else if (read_step) begin
      if (rd_ptr_q != PtrW'(N)) begin
        OutArray <= out_next;
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end else begin
        complete <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_edge_detection_all_directions.sv
// Self-checking bench for edge_detection_all_directions with a pixel-level reference model.
module tb_edge_detection_all_directions;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int DW = 8;
  localparam int TH = 64;
  localparam int N  = W * H;
  localparam int MAXV = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          resetBuff = 1'b0;
  logic          enb = 1'b0;
  logic          buffLRMode = 1'b0;
  logic          buffUDMode = 1'b0;
  logic [DW-1:0] leftRightArray = '0;
  logic [DW-1:0] upDownArray = '0;
  logic [DW-1:0] OutArray;
  logic          complete;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] img [H][W];

  edge_detection_all_directions #(
    .WIDTH (W),
    .HEIGHT(H),
    .DATA_W(DW),
    .THRESH(TH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .resetBuff     (resetBuff),
    .enb           (enb),
    .buffLRMode    (buffLRMode),
    .buffUDMode    (buffUDMode),
    .leftRightArray(leftRightArray),
    .upDownArray   (upDownArray),
    .OutArray      (OutArray),
    .complete      (complete)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: edge value of raster pixel k straight from the image
  function automatic int exp_px(int k);
    int r, c, gx, gy, s, a, b;
    r = k / W;
    c = k % W;
    gx = 0;
    gy = 0;
    a = int'(img[r][c]);
    if (c > 0) begin
      b = int'(img[r][c-1]);
      gx = (a > b) ? a - b : b - a;
    end
    if (r > 0) begin
      b = int'(img[r-1][c]);
      gy = (a > b) ? a - b : b - a;
    end
    s = gx + gy;
`ifdef EDGE_THRESHOLD_EN
    return (s >= TH) ? MAXV : 0;
`else
    return (s > MAXV) ? MAXV : s;
`endif
  endfunction

  task automatic clear_buff();
    resetBuff = 1'b1;
    enb = 1'($urandom);
    tick();
    resetBuff = 1'b0;
    enb = 1'b0;
  endtask

  // Mixed modes with enb=1; optionally check that OutArray holds exp_v
  task automatic hold_cycles(int n, bit chk, int exp_v, string name);
    logic [DW-1:0] e;
    e = DW'(exp_v);
    for (int i = 0; i < n; i++) begin
      buffLRMode = i[0];
      buffUDMode = ~i[0];
      enb = 1'b1;
      leftRightArray = DW'($urandom);
      upDownArray = DW'($urandom);
      tick();
      if (chk) begin
        n_checks++;
        if (OutArray !== e) begin
          n_fail++;
          $display("FAIL %s hold cycle %0d: OutArray=%0d expected %0d", name, i, OutArray, e);
        end
      end
    end
    enb = 1'b0;
  endtask

  // Feed `total` pixels on both streams; beyond N the values are random junk
  task automatic load_image(int total, int hold_at);
    for (int i = 0; i < total; i++) begin
      if (i == hold_at) hold_cycles(6, 1'b0, 0, "");
      buffLRMode = 1'b0;
      buffUDMode = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        enb = 1'b0;
        leftRightArray = DW'($urandom);
        upDownArray = DW'($urandom);
        tick();
      end
      enb = 1'b1;
      leftRightArray = (i < N) ? img[i / W][i % W] : DW'($urandom);
      upDownArray    = (i < N) ? img[i % H][i / H] : DW'($urandom);
      tick();
    end
    enb = 1'b0;
  endtask

  // Read pixels [from, to); with fin, also check complete timing and hold afterwards
  task automatic read_range(string name, int from, int to, bit fin);
    logic [DW-1:0] e;
    buffLRMode = 1'b1;
    buffUDMode = 1'b1;
    for (int k = from; k < to; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        enb = 1'b0;
        tick();
      end
      enb = 1'b1;
      tick();
      e = DW'(exp_px(k));
      n_checks++;
      if (OutArray !== e) begin
        n_fail++;
        $display("FAIL %s pixel %0d (r%0d c%0d): OutArray=%0d expected %0d",
                 name, k, k / W, k % W, OutArray, e);
      end
    end
    enb = 1'b0;
    if (fin) begin
      e = DW'(exp_px(N - 1));
      n_checks++;
      if (complete !== 1'b0) begin
        n_fail++;
        $display("FAIL %s complete after %0d edges: got %b expected 0", name, N, complete);
      end
      for (int j = 0; j < 2; j++) begin
        enb = 1'b1;
        tick();
        n_checks++;
        if (complete !== 1'b1 || OutArray !== e) begin
          n_fail++;
          $display("FAIL %s after-end edge %0d: complete=%b OutArray=%0d expected 1 / %0d",
                   name, j, complete, OutArray, e);
        end
      end
      enb = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enb = 1'b1;
    buffLRMode = 1'b1;
    buffUDMode = 1'b1;
    tick();
    tick();
    n_checks++;
    if (OutArray !== '0) begin
      n_fail++;
      $display("FAIL reset OutArray: got %0d expected 0", OutArray);
    end
    n_checks++;
    if (complete !== 1'b0) begin
      n_fail++;
      $display("FAIL reset complete: got %b expected 0", complete);
    end
    reset = 1'b1;
    enb = 1'b0;
    tick();
    // Buffer contents are unknown here: only count how many edges until complete
    for (int k = 0; k < N; k++) begin
      enb = 1'b0;
      tick();
      enb = 1'b1;
      tick();
    end
    enb = 1'b0;
    n_checks++;
    if (complete !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_count complete after N edges: got %b expected 0", complete);
    end
    enb = 1'b1;
    tick();
    enb = 1'b0;
    n_checks++;
    if (complete !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_count complete after N+1 edges: got %b expected 1", complete);
    end
  endtask

  task automatic test_flat();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = DW'(100);
    clear_buff();
    load_image(N, -1);
    read_range("flat", 0, N, 1'b1);
  endtask

  task automatic test_vstep();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < 8) ? DW'(0) : DW'(200);
    clear_buff();
    load_image(N, -1);
    read_range("vstep", 0, N, 1'b1);
  endtask

  task automatic test_saturation();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = ((r + c) % 2 == 1) ? DW'(255) : DW'(0);
    clear_buff();
    load_image(N, -1);
    read_range("saturation", 0, N, 1'b1);
    // Full reset from a non-zero OutArray with complete set
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++;
    if (OutArray !== '0 || complete !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midrun: OutArray=%0d complete=%b expected 0/0", OutArray, complete);
    end
  endtask

  task automatic test_overrun_hold();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = DW'($urandom);
    clear_buff();
    load_image(300, 100);
    read_range("overrun", 0, 5, 1'b0);
    hold_cycles(8, 1'b1, exp_px(4), "hold");
    read_range("overrun_tail", 5, N, 1'b1);
  endtask

  task automatic test_resetbuff();
    logic [DW-1:0] e;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = DW'($urandom);
    clear_buff();
    load_image(N, -1);
    read_range("rb_first", 0, 10, 1'b0);
    e = DW'(exp_px(9));
    resetBuff = 1'b1;
    enb = 1'b1;
    tick();
    resetBuff = 1'b0;
    enb = 1'b0;
    n_checks++;
    if (OutArray !== e || complete !== 1'b0) begin
      n_fail++;
      $display("FAIL resetbuff_mid: OutArray=%0d complete=%b expected %0d/0", OutArray, complete, e);
    end
    read_range("rb_restart", 0, N, 1'b1);
    resetBuff = 1'b1;
    tick();
    resetBuff = 1'b0;
    n_checks++;
    if (complete !== 1'b0) begin
      n_fail++;
      $display("FAIL resetbuff_complete: got %b expected 0", complete);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = DW'($urandom_range(0, 120));
    clear_buff();
    load_image(N, 37);
    read_range("random", 0, N, 1'b1);
  endtask

  initial begin
    test_reset();
    test_flat();
    test_vstep();
    test_saturation();
    test_overrun_hold();
    test_resetbuff();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_detection_all_directions.md
Name: edge_detection_all_directions

Overview:
- Single-clock streaming edge detector for one greyscale image of WIDTH x HEIGHT pixels.
- Load phase: the same image arrives on two streams, row-major (left-right) and column-major (up-down), one pixel per stream per enabled cycle. Horizontal and vertical gradients are stored in internal buffers.
- Readout phase: the combined edge value for each pixel is streamed out in row-major order, and the end of the stream is flagged.

Parameters:
- WIDTH, 16, image columns.
- HEIGHT, 16, image rows.
- DATA_W, 8, pixel and result width in bits.
- THRESH, 64, edge threshold; used only with EDGE_THRESHOLD_EN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low full reset.
- resetBuff  in  1  synchronous, active-high clear of pointers and complete; buffer contents are kept.
- enb  in  1  enables one load or read step this cycle.
- buffLRMode  in  1  0 = load, 1 = readout; applies to the left-right side.
- buffUDMode  in  1  0 = load, 1 = readout; applies to the up-down side.
- leftRightArray  in  DATA_W  row-major pixel stream.
- upDownArray  in  DATA_W  column-major pixel stream.
- OutArray  out  DATA_W  edge result, registered.
- complete  out  1  readout finished, sticky.

Behaviour:
- N = WIDTH*HEIGHT. Two N-entry DATA_W buffers: GX and GY.
- Reset (reset=0 at a clock edge):
  - OutArray=0, complete=0.
  - lr_ptr, ud_ptr and rd_ptr = 0; previous-pixel registers = 0.
  - Buffer contents are unspecified.
  - reset has priority over resetBuff and all other inputs.
- resetBuff=1 (with reset=1): clears lr_ptr, ud_ptr, rd_ptr, the previous-pixel registers and complete. OutArray holds.
- Mode encoding:
  - Both mode bits 0 = LOAD.
  - Both mode bits 1 = READ.
  - Mixed values = HOLD: no state changes.
- LOAD, each edge with enb=1:
  - LR side, if lr_ptr<N:
    - pixel p = leftRightArray; column c = lr_ptr mod WIDTH.
    - GX[lr_ptr] = |p - prevLR|, or 0 when c=0.
    - prevLR <= p; lr_ptr++.
  - UD side, if ud_ptr<N:
    - q = upDownArray; r = ud_ptr mod HEIGHT; c = ud_ptr div HEIGHT.
    - GY[r*WIDTH+c] = |q - prevUD|, or 0 when r=0.
    - prevUD <= q; ud_ptr++.
  - Once a pointer equals N, further pixels on that stream are ignored. The pointer saturates at N and does not wrap.
  - The two sides advance independently in the same cycle.
  - Absolute differences are unsigned DATA_W, with no overflow.
- READ, each edge with enb=1 and complete=0:
  - If rd_ptr<N: OutArray <= f(GX[rd_ptr], GY[rd_ptr]); rd_ptr++.
  - If rd_ptr==N: complete <= 1; OutArray holds.
  - Latency: pixel k appears on OutArray after the (k+1)th enabled READ edge. complete rises on edge N+1.
- Once complete=1, READ does nothing until reset or resetBuff.
- enb=0: everything holds, in any mode.
- Switching modes mid-operation does not clear pointers.
- Reading before the load is complete returns whatever the buffers currently contain.
- Default f = min(GX+GY, 2^DATA_W - 1), a saturating add.

Optional Feature:
- Macro EDGE_THRESHOLD_EN.
- Defined: f = (GX+GY >= THRESH) ? 2^DATA_W-1 : 0, giving a binary edge map.
- Undefined: f is the saturating sum and THRESH is unused.

Decomposition:
- Shared package edge_det_pkg:
  - DATA_W default.
  - Mode enum: LOAD=2'b00, READ=2'b11, HOLD=others.
  - A function for the saturating add / threshold.
- One sub-module, grad_stream_unit, instantiated twice (LR and UD). It holds the previous pixel, the pointer, the absolute-difference logic and the address generation. The row-major or column-major address mapping is selected by a parameter.
- Buffers are inferred arrays in the top level.

Test Plan:
- Reset: reset=0 for 2 cycles, then 1 -> OutArray=0, complete=0. READ with enb toggled -> exactly N pixels are emitted, then complete=1.
- Flat image (all pixels 100), 16x16 loaded on both streams, then READ -> 256 outputs, all 0; complete rises on the 257th enabled READ edge.
- Vertical step (columns 0-7 = 0, 8-15 = 200) -> column 8 outputs 200, all others 0. With EDGE_THRESHOLD_EN and THRESH=64 -> column 8 = 255.
- Saturation: pixel (r,c) = 255 if r+c odd else 0 -> interior outputs saturate at 255; row 0 / column 0 edges give 255 from a single gradient.
- Overrun and HOLD: 300 pixels streamed -> the last 44 are ignored. With mixed modes (1,0) and enb=1, no pointer moves and OutArray holds.
- resetBuff=1 mid-readout at rd_ptr=10 -> rd_ptr and complete clear; the next READ restarts at pixel 0 with unchanged buffer data.
